// File: rtl/ibex_wb_arbiter_pkg.sv
// ibex_wb_arbiter_pkg
//  Shared types and constants for the register-file write-back arbiter.
//  - wb_src_e    : per-RF-port grant encoding.
//  - WB_ARB_MAX_OUTSTANDING_LIMIT : upper bound on in-flight multi-cycle FPU ops.
//  - wb_pick()   : fixed-priority grant (LSU > FPU source > ID) for one port.
package ibex_wb_arbiter_pkg;

    typedef enum logic [1:0] {
        WB_SRC_NONE,
        WB_SRC_LSU,
        WB_SRC_FPU,
        WB_SRC_ID
    } wb_src_e;

    localparam int unsigned WB_ARB_MAX_OUTSTANDING_LIMIT = 4;

    // Wide enough to hold 0..WB_ARB_MAX_OUTSTANDING_LIMIT.
    localparam int unsigned WB_ARB_CNT_W = $clog2(WB_ARB_MAX_OUTSTANDING_LIMIT + 1);

    function automatic wb_src_e wb_pick(input logic lsu_req, input logic fpu_req,
                                        input logic id_req);
        if (lsu_req) begin
            return WB_SRC_LSU;
        end else if (fpu_req) begin
            return WB_SRC_FPU;
        end else if (id_req) begin
            return WB_SRC_ID;
        end
        return WB_SRC_NONE;
    endfunction

endpackage

// File: rtl/ibex_wb_scoreboard.sv
// ibex_wb_scoreboard
//  Busy masks of register destinations awaiting a multi-cycle FPU result,
//  plus the count of in-flight FPU ops.
//  Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   set_i/set_is_fp_i/set_rd_i  accepted FPU issue (marks rd busy, count +1)
//   clr_i/clr_is_fp_i/clr_rd_i  FPU result written (clears rd, count -1)
//   int_busy_o / fp_busy_o   busy masks (int bit 0 never set)
//   full_o                   outstanding count has reached MaxOutstanding
module ibex_wb_scoreboard
    import ibex_wb_arbiter_pkg::*;
#(
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        set_i,
    input  logic        set_is_fp_i,
    input  logic [4:0]  set_rd_i,
    input  logic        clr_i,
    input  logic        clr_is_fp_i,
    input  logic [4:0]  clr_rd_i,
    output logic [31:0] int_busy_o,
    output logic [31:0] fp_busy_o,
    output logic        full_o
);

    localparam logic [WB_ARB_CNT_W-1:0] MaxCnt = WB_ARB_CNT_W'(MaxOutstanding);

    logic [31:0]             int_busy_q, int_busy_d;
    logic [31:0]             fp_busy_q, fp_busy_d;
    logic [WB_ARB_CNT_W-1:0] cnt_q, cnt_d;

    // Clear is applied before set; a legal issue never targets a busy rd,
    // so the two only ever touch different bits.
    always_comb begin
        int_busy_d = int_busy_q;
        fp_busy_d  = fp_busy_q;
        if (clr_i) begin
            if (clr_is_fp_i) fp_busy_d[clr_rd_i] = 1'b0;
            else             int_busy_d[clr_rd_i] = 1'b0;
        end
        if (set_i) begin
            if (set_is_fp_i) fp_busy_d[set_rd_i] = 1'b1;
            else             int_busy_d[set_rd_i] = 1'b1;
        end
        // x0 is never a real hazard, but an x0 issue still counts below.
        int_busy_d[0] = 1'b0;
    end

    always_comb begin
        cnt_d = cnt_q;
        case ({set_i, clr_i})
            2'b10:   cnt_d = cnt_q + WB_ARB_CNT_W'(1);
            2'b01:   cnt_d = cnt_q - WB_ARB_CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            int_busy_q <= '0;
            fp_busy_q  <= '0;
            cnt_q      <= '0;
        end else begin
            int_busy_q <= int_busy_d;
            fp_busy_q  <= fp_busy_d;
            cnt_q      <= cnt_d;
        end
    end

    assign int_busy_o = int_busy_q;
    assign fp_busy_o  = fp_busy_q;
    assign full_o     = (cnt_q >= MaxCnt);

endmodule

// File: rtl/ibex_wb_arbiter.sv
// ibex_wb_arbiter
//  Shares the int and FP register-file write ports between LSU load data,
//  single-cycle ID/EX results and out-of-order multi-cycle FPU results.
//  Per-port fixed priority LSU > FPU > ID, combinational. An FPU result that
//  loses to the LSU is parked in a one-entry hold buffer and written on the
//  first cycle the LSU leaves that port free.
//  Ports:
//   clk_i, rst_ni                     clock, asynchronous active-low reset
//   id_*                              ID/EX result (valid/ready handshake)
//   lsu_*                             load response (never stalled)
//   fpu_issue_* / fpu_issue_ready_o   multi-cycle FPU issue and its permission
//   fpu_valid_i/fpu_ready_o/fpu_*     FPU result handshake
//   rf_* / fp_rf_*                    int / FP RF write ports
//   int_busy_o / fp_busy_o            pending FPU destinations for hazard checks
//   perf_fpu_hold_o / perf_id_stall_o performance counters
//  Build option: IBEX_WB_ARB_PERF_EN enables 16-bit saturating perf counters;
//  without it both perf outputs are constant zero.
module ibex_wb_arbiter
    import ibex_wb_arbiter_pkg::*;
#(
    parameter int unsigned FPU_WIDTH      = 32,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 id_valid_i,
    output logic                 id_ready_o,
    input  logic                 id_is_fp_i,
    input  logic [4:0]           id_waddr_i,
    input  logic [FPU_WIDTH-1:0] id_wdata_i,
    input  logic                 lsu_valid_i,
    input  logic                 lsu_is_fp_i,
    input  logic [4:0]           lsu_waddr_i,
    input  logic [FPU_WIDTH-1:0] lsu_wdata_i,
    input  logic                 fpu_issue_i,
    input  logic                 fpu_issue_is_fp_i,
    input  logic [4:0]           fpu_issue_rd_i,
    output logic                 fpu_issue_ready_o,
    input  logic                 fpu_valid_i,
    output logic                 fpu_ready_o,
    input  logic                 fpu_is_fp_i,
    input  logic [4:0]           fpu_waddr_i,
    input  logic [FPU_WIDTH-1:0] fpu_wdata_i,
    output logic                 rf_we_o,
    output logic [4:0]           rf_waddr_o,
    output logic [31:0]          rf_wdata_o,
    output logic                 fp_rf_we_o,
    output logic [4:0]           fp_rf_waddr_o,
    output logic [FPU_WIDTH-1:0] fp_rf_wdata_o,
    output logic [31:0]          int_busy_o,
    output logic [31:0]          fp_busy_o,
    output logic [15:0]          perf_fpu_hold_o,
    output logic [15:0]          perf_id_stall_o
);

    logic                 hold_valid_q, hold_valid_d;
    logic                 hold_is_fp_q;
    logic [4:0]           hold_waddr_q;
    logic [FPU_WIDTH-1:0] hold_wdata_q;

    logic                 fsrc_valid, fsrc_is_fp;
    logic [4:0]           fsrc_waddr;
    logic [FPU_WIDTH-1:0] fsrc_wdata;
    logic                 lsu_int, lsu_fp;
    logic                 hold_fill, fpu_write;
    wb_src_e              int_src, fp_src;
    logic                 sb_full;

    assign lsu_int = lsu_valid_i & ~lsu_is_fp_i;
    assign lsu_fp  = lsu_valid_i &  lsu_is_fp_i;

    // The hold entry always outranks a new FPU result; fpu_ready_o is low
    // while it is occupied, so a new result is never lost.
    assign fsrc_valid = hold_valid_q | fpu_valid_i;
    assign fsrc_is_fp = hold_valid_q ? hold_is_fp_q : fpu_is_fp_i;
    assign fsrc_waddr = hold_valid_q ? hold_waddr_q : fpu_waddr_i;
    assign fsrc_wdata = hold_valid_q ? hold_wdata_q : fpu_wdata_i;

    assign int_src = wb_pick(lsu_int, fsrc_valid & ~fsrc_is_fp, id_valid_i & ~id_is_fp_i);
    assign fp_src  = wb_pick(lsu_fp,  fsrc_valid &  fsrc_is_fp, id_valid_i &  id_is_fp_i);

    always_comb begin
        rf_we_o       = 1'b0;
        rf_waddr_o    = '0;
        rf_wdata_o    = '0;
        fp_rf_we_o    = 1'b0;
        fp_rf_waddr_o = '0;
        fp_rf_wdata_o = '0;
        case (int_src)
            WB_SRC_LSU: begin
                rf_we_o    = 1'b1;
                rf_waddr_o = lsu_waddr_i;
                rf_wdata_o = lsu_wdata_i[31:0];
            end
            WB_SRC_FPU: begin
                rf_we_o    = 1'b1;
                rf_waddr_o = fsrc_waddr;
                rf_wdata_o = fsrc_wdata[31:0];
            end
            WB_SRC_ID: begin
                rf_we_o    = 1'b1;
                rf_waddr_o = id_waddr_i;
                rf_wdata_o = id_wdata_i[31:0];
            end
            default: ;
        endcase
        case (fp_src)
            WB_SRC_LSU: begin
                fp_rf_we_o    = 1'b1;
                fp_rf_waddr_o = lsu_waddr_i;
                fp_rf_wdata_o = lsu_wdata_i;
            end
            WB_SRC_FPU: begin
                fp_rf_we_o    = 1'b1;
                fp_rf_waddr_o = fsrc_waddr;
                fp_rf_wdata_o = fsrc_wdata;
            end
            WB_SRC_ID: begin
                fp_rf_we_o    = 1'b1;
                fp_rf_waddr_o = id_waddr_i;
                fp_rf_wdata_o = id_wdata_i;
            end
            default: ;
        endcase
    end

    // ID is accepted exactly when it wins its port; both higher-priority
    // sources drain in bounded time, which bounds the stall.
    assign id_ready_o = ~id_valid_i | (int_src == WB_SRC_ID) | (fp_src == WB_SRC_ID);

    assign fpu_ready_o = ~hold_valid_q;
    assign fpu_write   = (int_src == WB_SRC_FPU) | (fp_src == WB_SRC_FPU);
    assign hold_fill   = fpu_valid_i & ~hold_valid_q & (fpu_is_fp_i ? lsu_fp : lsu_int);

    always_comb begin
        hold_valid_d = hold_valid_q;
        if (hold_fill) begin
            hold_valid_d = 1'b1;
        end else if (hold_valid_q && fpu_write) begin
            hold_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_valid_q <= 1'b0;
        end else begin
            hold_valid_q <= hold_valid_d;
        end
    end

    // Payload is only meaningful while hold_valid_q is set.
    always_ff @(posedge clk_i) begin
        if (hold_fill) begin
            hold_is_fp_q <= fpu_is_fp_i;
            hold_waddr_q <= fpu_waddr_i;
            hold_wdata_q <= fpu_wdata_i;
        end
    end

    ibex_wb_scoreboard #(
        .MaxOutstanding (MaxOutstanding)
    ) u_scoreboard (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .set_i       (fpu_issue_i & fpu_issue_ready_o),
        .set_is_fp_i (fpu_issue_is_fp_i),
        .set_rd_i    (fpu_issue_rd_i),
        .clr_i       (fpu_write),
        .clr_is_fp_i (fsrc_is_fp),
        .clr_rd_i    (fsrc_waddr),
        .int_busy_o  (int_busy_o),
        .fp_busy_o   (fp_busy_o),
        .full_o      (sb_full)
    );

    assign fpu_issue_ready_o = ~sb_full &
        ~(fpu_issue_is_fp_i ? fp_busy_o[fpu_issue_rd_i] : int_busy_o[fpu_issue_rd_i]);

`ifdef IBEX_WB_ARB_PERF_EN
    logic [15:0] perf_hold_q, perf_stall_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_hold_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            if (hold_valid_q && (perf_hold_q != 16'hFFFF)) begin
                perf_hold_q <= perf_hold_q + 16'd1;
            end
            if (id_valid_i && !id_ready_o && (perf_stall_q != 16'hFFFF)) begin
                perf_stall_q <= perf_stall_q + 16'd1;
            end
        end
    end

    assign perf_fpu_hold_o = perf_hold_q;
    assign perf_id_stall_o = perf_stall_q;
`else
    assign perf_fpu_hold_o = '0;
    assign perf_id_stall_o = '0;
`endif

    // An x0 integer result never has a busy bit to match.
    a_fpu_result_busy: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (fpu_valid_i && fpu_ready_o && (fpu_is_fp_i || (fpu_waddr_i != 5'd0))) |->
        (fpu_is_fp_i ? fp_busy_o[fpu_waddr_i] : int_busy_o[fpu_waddr_i]));

    a_no_over_issue: assert property (@(posedge clk_i) disable iff (!rst_ni)
        fpu_issue_i |-> !sb_full);

    a_one_write_per_port: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0({lsu_int, (int_src == WB_SRC_FPU), (int_src == WB_SRC_ID)}) &&
        $onehot0({lsu_fp, (fp_src == WB_SRC_FPU), (fp_src == WB_SRC_ID)}));

endmodule

// File: tb/tb_ibex_wb_arbiter.sv
module tb_ibex_wb_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        id_valid_i, id_ready_o, id_is_fp_i;
    logic [4:0]  id_waddr_i;
    logic [31:0] id_wdata_i;
    logic        lsu_valid_i, lsu_is_fp_i;
    logic [4:0]  lsu_waddr_i;
    logic [31:0] lsu_wdata_i;
    logic        fpu_issue_i, fpu_issue_is_fp_i, fpu_issue_ready_o;
    logic [4:0]  fpu_issue_rd_i;
    logic        fpu_valid_i, fpu_ready_o, fpu_is_fp_i;
    logic [4:0]  fpu_waddr_i;
    logic [31:0] fpu_wdata_i;
    logic        rf_we_o, fp_rf_we_o;
    logic [4:0]  rf_waddr_o, fp_rf_waddr_o;
    logic [31:0] rf_wdata_o, fp_rf_wdata_o;
    logic [31:0] int_busy_o, fp_busy_o;
    logic [15:0] perf_fpu_hold_o, perf_id_stall_o;

    int n_vec = 0;
    int n_err = 0;

`ifdef IBEX_WB_ARB_PERF_EN
    localparam logic [15:0] PerfOne = 16'd1;
`else
    localparam logic [15:0] PerfOne = 16'd0;
`endif

    always #5 clk_i = ~clk_i;

    ibex_wb_arbiter #(
        .FPU_WIDTH      (32),
        .MaxOutstanding (2)
    ) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .id_valid_i        (id_valid_i),
        .id_ready_o        (id_ready_o),
        .id_is_fp_i        (id_is_fp_i),
        .id_waddr_i        (id_waddr_i),
        .id_wdata_i        (id_wdata_i),
        .lsu_valid_i       (lsu_valid_i),
        .lsu_is_fp_i       (lsu_is_fp_i),
        .lsu_waddr_i       (lsu_waddr_i),
        .lsu_wdata_i       (lsu_wdata_i),
        .fpu_issue_i       (fpu_issue_i),
        .fpu_issue_is_fp_i (fpu_issue_is_fp_i),
        .fpu_issue_rd_i    (fpu_issue_rd_i),
        .fpu_issue_ready_o (fpu_issue_ready_o),
        .fpu_valid_i       (fpu_valid_i),
        .fpu_ready_o       (fpu_ready_o),
        .fpu_is_fp_i       (fpu_is_fp_i),
        .fpu_waddr_i       (fpu_waddr_i),
        .fpu_wdata_i       (fpu_wdata_i),
        .rf_we_o           (rf_we_o),
        .rf_waddr_o        (rf_waddr_o),
        .rf_wdata_o        (rf_wdata_o),
        .fp_rf_we_o        (fp_rf_we_o),
        .fp_rf_waddr_o     (fp_rf_waddr_o),
        .fp_rf_wdata_o     (fp_rf_wdata_o),
        .int_busy_o        (int_busy_o),
        .fp_busy_o         (fp_busy_o),
        .perf_fpu_hold_o   (perf_fpu_hold_o),
        .perf_id_stall_o   (perf_id_stall_o)
    );

    typedef struct {
        logic        id_v;
        logic        id_fp;
        logic [4:0]  id_a;
        logic [31:0] id_d;
        logic        lsu_v;
        logic        lsu_fp;
        logic [4:0]  lsu_a;
        logic [31:0] lsu_d;
        logic        e_rf_we;
        logic [4:0]  e_rf_a;
        logic [31:0] e_rf_d;
        logic        e_fp_we;
        logic [4:0]  e_fp_a;
        logic [31:0] e_fp_d;
        logic        e_rdy;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        id_valid_i = 0; id_is_fp_i = 0; id_waddr_i = 0; id_wdata_i = 0;
        lsu_valid_i = 0; lsu_is_fp_i = 0; lsu_waddr_i = 0; lsu_wdata_i = 0;
        fpu_issue_i = 0; fpu_issue_is_fp_i = 0; fpu_issue_rd_i = 0;
        fpu_valid_i = 0; fpu_is_fp_i = 0; fpu_waddr_i = 0; fpu_wdata_i = 0;
    endtask

    // Advance to just after the next rising edge; drive, then settle and sample.
    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    function automatic logic [76:0] outs();
        return {rf_we_o, rf_waddr_o, rf_wdata_o, fp_rf_we_o, fp_rf_waddr_o, fp_rf_wdata_o,
                id_ready_o};
    endfunction

    task automatic issue(input logic is_fp, input logic [4:0] rd);
        fpu_issue_i = 1'b1; fpu_issue_is_fp_i = is_fp; fpu_issue_rd_i = rd;
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b0, 5'd5,  32'h0000_1234, 1'b0, 1'b0, 5'd0,  32'h0,
                    1'b1, 5'd5,  32'h0000_1234, 1'b0, 5'd0,  32'h0,         1'b1};
        vecs[1] = '{1'b1, 1'b1, 5'd3,  32'h3F80_0000, 1'b1, 1'b0, 5'd6,  32'hCAFE_0006,
                    1'b1, 5'd6,  32'hCAFE_0006, 1'b1, 5'd3,  32'h3F80_0000, 1'b1};
        vecs[2] = '{1'b1, 1'b0, 5'd9,  32'h99,        1'b1, 1'b0, 5'd6,  32'h66,
                    1'b1, 5'd6,  32'h66,        1'b0, 5'd0,  32'h0,         1'b0};
        vecs[3] = '{1'b1, 1'b1, 5'd4,  32'h44,        1'b1, 1'b1, 5'd2,  32'h22,
                    1'b0, 5'd0,  32'h0,         1'b1, 5'd2,  32'h22,        1'b0};
        vecs[4] = '{1'b0, 1'b0, 5'd7,  32'h77,        1'b0, 1'b1, 5'd8,  32'h88,
                    1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         1'b1};
        vecs[5] = '{1'b0, 1'b0, 5'd0,  32'h0,         1'b1, 1'b1, 5'd1,  32'hDEAD_BEEF,
                    1'b0, 5'd0,  32'h0,         1'b1, 5'd1,  32'hDEAD_BEEF, 1'b1};
        vecs[6] = '{1'b1, 1'b1, 5'd31, 32'hFFFF_FFFF, 1'b0, 1'b0, 5'd0,  32'h0,
                    1'b0, 5'd0,  32'h0,         1'b1, 5'd31, 32'hFFFF_FFFF, 1'b1};
        vecs[7] = '{1'b1, 1'b0, 5'd10, 32'hA0,        1'b1, 1'b1, 5'd9,  32'h90,
                    1'b1, 5'd10, 32'hA0,        1'b1, 5'd9,  32'h90,        1'b1};

        idle();
        rst_ni = 1'b0;
        #12;
        // Reset state, checked while reset is held.
        chk("rst_fpu_ready",   128'(fpu_ready_o),       128'(1'b1));
        chk("rst_issue_ready", 128'(fpu_issue_ready_o), 128'(1'b1));
        chk("rst_busy",        128'({int_busy_o, fp_busy_o}), 128'(64'h0));
        chk("rst_outs",        128'(outs()),            128'({76'h0, 1'b1}));
        chk("rst_perf",        128'({perf_fpu_hold_o, perf_id_stall_o}), 128'(32'h0));
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;

        // Combinational arbitration, no FPU traffic.
        for (int i = 0; i < 8; i++) begin
            cyc();
            id_valid_i = vecs[i].id_v;   id_is_fp_i  = vecs[i].id_fp;
            id_waddr_i = vecs[i].id_a;   id_wdata_i  = vecs[i].id_d;
            lsu_valid_i = vecs[i].lsu_v; lsu_is_fp_i = vecs[i].lsu_fp;
            lsu_waddr_i = vecs[i].lsu_a; lsu_wdata_i = vecs[i].lsu_d;
            #1;
            chk($sformatf("vec%0d", i), 128'(outs()),
                128'({vecs[i].e_rf_we, vecs[i].e_rf_a, vecs[i].e_rf_d,
                      vecs[i].e_fp_we, vecs[i].e_fp_a, vecs[i].e_fp_d, vecs[i].e_rdy}));
        end

        // FPU result collides with an FP load and is parked, then drained.
        do_reset();
        cyc(); issue(1'b1, 5'd7); #1;
        chk("s3_issue_ready", 128'(fpu_issue_ready_o), 128'(1'b1));
        cyc(); idle();
        fpu_valid_i = 1; fpu_is_fp_i = 1; fpu_waddr_i = 5'd7; fpu_wdata_i = 32'h0000_C0DE;
        lsu_valid_i = 1; lsu_is_fp_i = 1; lsu_waddr_i = 5'd2; lsu_wdata_i = 32'h0000_AAAA;
        #1;
        chk("s3_busy7",      128'(fp_busy_o), 128'(32'h80));
        chk("s3_fpu_ready0", 128'(fpu_ready_o), 128'(1'b1));
        chk("s3_lsu_wins",   128'({fp_rf_we_o, fp_rf_waddr_o, fp_rf_wdata_o}),
                             128'({1'b1, 5'd2, 32'h0000_AAAA}));
        cyc(); fpu_valid_i = 0; lsu_waddr_i = 5'd3; lsu_wdata_i = 32'h0000_BBBB; #1;
        chk("s3_held_ready", 128'(fpu_ready_o), 128'(1'b0));
        chk("s3_lsu_again",  128'({fp_rf_we_o, fp_rf_waddr_o, fp_rf_wdata_o, fp_busy_o}),
                             128'({1'b1, 5'd3, 32'h0000_BBBB, 32'h80}));
        cyc(); idle(); #1;
        chk("s3_drain",       128'({fp_rf_we_o, fp_rf_waddr_o, fp_rf_wdata_o}),
                              128'({1'b1, 5'd7, 32'h0000_C0DE}));
        chk("s3_drain_ready", 128'(fpu_ready_o), 128'(1'b0));
        cyc(); #1;
        chk("s3_after", 128'({fp_busy_o, fpu_ready_o, fp_rf_we_o}), 128'({32'h0, 1'b1, 1'b0}));

        // Outstanding limit and busy-destination gating.
        do_reset();
        cyc(); issue(1'b1, 5'd1); #1;
        chk("s4_iss1", 128'(fpu_issue_ready_o), 128'(1'b1));
        cyc(); issue(1'b0, 5'd4); #1;
        chk("s4_iss2", 128'(fpu_issue_ready_o), 128'(1'b1));
        cyc(); idle(); fpu_issue_is_fp_i = 1; fpu_issue_rd_i = 5'd10;
        fpu_valid_i = 1; fpu_is_fp_i = 1; fpu_waddr_i = 5'd1; fpu_wdata_i = 32'h11;
        #1;
        chk("s4_full",   128'(fpu_issue_ready_o), 128'(1'b0));
        chk("s4_masks",  128'({int_busy_o, fp_busy_o}), 128'({32'h10, 32'h2}));
        chk("s4_direct", 128'({fp_rf_we_o, fp_rf_waddr_o, fp_rf_wdata_o}),
                         128'({1'b1, 5'd1, 32'h11}));
        cyc(); fpu_valid_i = 0; #1;
        chk("s4_ready_again", 128'(fpu_issue_ready_o), 128'(1'b1));
        issue(1'b1, 5'd7);
        cyc(); idle();
        fpu_valid_i = 1; fpu_is_fp_i = 0; fpu_waddr_i = 5'd4; fpu_wdata_i = 32'h44;
        #1;
        chk("s4_int_result", 128'({rf_we_o, rf_waddr_o, rf_wdata_o}), 128'({1'b1, 5'd4, 32'h44}));
        cyc(); idle(); fpu_issue_is_fp_i = 1; fpu_issue_rd_i = 5'd7; #1;
        chk("s4_busy_f7", 128'(fpu_issue_ready_o), 128'(1'b0));
        fpu_issue_rd_i = 5'd10; #1;
        chk("s4_free_f10", 128'(fpu_issue_ready_o), 128'(1'b1));

        // x0 issue counts as outstanding without setting a bit.
        do_reset();
        cyc(); issue(1'b0, 5'd0);
        cyc(); idle(); fpu_issue_is_fp_i = 1; fpu_issue_rd_i = 5'd9; #1;
        chk("x0_nobit",  128'(int_busy_o), 128'(32'h0));
        chk("x0_count1", 128'(fpu_issue_ready_o), 128'(1'b1));
        issue(1'b1, 5'd9);
        cyc(); idle(); fpu_issue_is_fp_i = 1; fpu_issue_rd_i = 5'd12; #1;
        chk("x0_full", 128'(fpu_issue_ready_o), 128'(1'b0));

        // Hold drain outranks a pending ID FP write.
        do_reset();
        cyc(); issue(1'b1, 5'd8);
        cyc(); idle();
        fpu_valid_i = 1; fpu_is_fp_i = 1; fpu_waddr_i = 5'd8; fpu_wdata_i = 32'h88;
        lsu_valid_i = 1; lsu_is_fp_i = 1; lsu_waddr_i = 5'd2; lsu_wdata_i = 32'h22;
        cyc(); idle();
        id_valid_i = 1; id_is_fp_i = 1; id_waddr_i = 5'd5; id_wdata_i = 32'h55;
        #1;
        chk("s5_hold_first", 128'({fp_rf_we_o, fp_rf_waddr_o, fp_rf_wdata_o, id_ready_o}),
                             128'({1'b1, 5'd8, 32'h88, 1'b0}));
        cyc(); #1;
        chk("s5_id_next", 128'({fp_rf_we_o, fp_rf_waddr_o, fp_rf_wdata_o, id_ready_o, fp_busy_o}),
                          128'({1'b1, 5'd5, 32'h55, 1'b1, 32'h0}));
        cyc(); idle(); #1;
        chk("s5_perf", 128'({perf_fpu_hold_o, perf_id_stall_o}), 128'({PerfOne, PerfOne}));

        // Reset mid-operation with the hold entry full and busy bits set.
        do_reset();
        cyc(); issue(1'b1, 5'd7);
        cyc(); issue(1'b0, 5'd3);
        cyc(); idle();
        fpu_valid_i = 1; fpu_is_fp_i = 1; fpu_waddr_i = 5'd7; fpu_wdata_i = 32'h77;
        lsu_valid_i = 1; lsu_is_fp_i = 1; lsu_waddr_i = 5'd1; lsu_wdata_i = 32'h11;
        cyc(); fpu_valid_i = 0; #1;
        chk("s6_pre", 128'({fpu_ready_o, int_busy_o, fp_busy_o}), 128'({1'b0, 32'h8, 32'h80}));
        idle(); fpu_issue_is_fp_i = 1; fpu_issue_rd_i = 5'd7;
        rst_ni = 1'b0;
        #1;
        chk("s6_in_rst", 128'({fpu_ready_o, fpu_issue_ready_o, int_busy_o, fp_busy_o,
                               rf_we_o, fp_rf_we_o}),
                         128'({1'b1, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0}));
        cyc(); rst_ni = 1'b1; #1;
        chk("s6_release", 128'({rf_we_o, fp_rf_we_o, fpu_ready_o}), 128'({1'b0, 1'b0, 1'b1}));
        cyc(); #1;
        chk("s6_after", 128'({rf_we_o, fp_rf_we_o, fp_busy_o}), 128'({1'b0, 1'b0, 32'h0}));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
